// File: rtl/fp_writeback_arbiter.sv
// Round-robin merge of two FP result producers into an in-order write queue driving the register file write port.
// Latency: accepted at edge k, written at edge k+1 when not held; backpressure: both readies drop while the queue is full.
module fp_writeback_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ADDR_W-1:0]         a_addr,
    input  logic [DATA_W-1:0]         a_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [ADDR_W-1:0]         b_addr,
    input  logic [DATA_W-1:0]         b_data,
    input  logic                      W_Hold,
    output logic                      W_En,
    output logic [ADDR_W-1:0]         W_Addr,
    output logic [DATA_W-1:0]         WR,
    output logic [(1<<ADDR_W)-1:0]    pend_mask,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              last_b;
    logic              full;
    logic              empty;
    logic              push_a;
    logic              push_b;
    logic              push;
    logic              pop;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // Ready depends on the other side's valid only to break ties toward the side not granted last.
    assign a_ready = !rst && !full && (!b_valid || last_b);
    assign b_ready = !rst && !full && (!a_valid || !last_b);

    assign push_a = a_valid && a_ready;
    assign push_b = b_valid && b_ready;
    assign push   = push_a || push_b;

    assign W_En   = !empty && !W_Hold;
    assign pop    = W_En;
    assign W_Addr = empty ? '0 : q_addr[head];
    assign WR     = empty ? '0 : q_data[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            last_b <= 1'b1;
        end else begin
            if (push) begin
                tail   <= tail + 1'b1;
                last_b <= push_b;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= push_a ? a_addr : b_addr;
            q_data[tail] <= push_a ? a_data : b_data;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count) begin
                pend_mask[q_addr[head + PW'(i)]] = 1'b1;
            end
        end
    end

endmodule
